// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU host-write path: video timing,
// the commit address and the write-scheduler entry/state types.
package ppu_pkg;

    localparam int VACTIVE = 480;
    localparam int VTOTAL  = 525;
    localparam int HTOTAL  = 1600;

    localparam logic [15:0] COMMIT_ADDR = 16'hF000;

    typedef enum logic [1:0] {
        WAIT,
        DRAIN,
        CLOSED
    } wsched_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wsched_entry_t;

    localparam int ENTRY_W = $bits(wsched_entry_t);

endpackage

// File: rtl/memory.sv
// Simple dual-port storage RAM: one synchronous write port and one
// registered read port, so a read issued at edge k is visible after edge k.
module memory #(
    parameter int WIDTH  = 48,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ppu_write_scheduler.sv
// Holds host writes to the PPU tables in a FIFO and releases them only inside
// the vertical-blank drain window. Optional macro: PPU_WSCHED_COMMIT_EN.
module ppu_write_scheduler
    import ppu_pkg::*;
#(
    parameter int DEPTH            = 64,
    parameter int DRAIN_FIRST_LINE = VACTIVE,
    parameter int DRAIN_LAST_LINE  = VTOTAL - 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [15:0]             address,
    input  logic [31:0]             writedata,
    output logic                    waitrequest,
    input  logic [10:0]             hcount,
    input  logic [9:0]              vcount,
    output logic                    tbl_write,
    output logic [15:0]             tbl_address,
    output logic [31:0]             tbl_writedata,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [9:0] FIRST_LINE = 10'(DRAIN_FIRST_LINE);
    localparam logic [9:0] LAST_LINE  = 10'(DRAIN_LAST_LINE);

    wsched_state_t state, state_nxt;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0] drain_end;

    logic host_wr, is_commit, push, pop;
    logic full, drainable, win, win_q;

    logic [ENTRY_W-1:0] wr_entry_p0;
    logic [ENTRY_W-1:0] rd_raw_p1;
    wsched_entry_t      rd_entry_p1;
    logic               vld_p1;

    // Horizontal position is not needed: the window is whole lines.
    logic unused_hcount;
    assign unused_hcount = ^hcount;

    // One extra pointer bit distinguishes full from empty on wrap.
    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign waitrequest = full;

    assign host_wr = chipselect && write;
    assign win     = (vcount >= FIRST_LINE) && (vcount <= LAST_LINE);

`ifdef PPU_WSCHED_COMMIT_EN
    logic [PW-1:0] commit_ptr;

    assign is_commit = (address == COMMIT_ADDR);
    assign drain_end = commit_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_ptr <= '0;
        end else if (host_wr && !full && is_commit) begin
            commit_ptr <= wr_ptr_nxt;
        end
    end
`else
    assign is_commit = 1'b0;
    assign drain_end = wr_ptr;
`endif

    assign push      = host_wr && !full && !is_commit;
    assign drainable = (rd_ptr != drain_end);
    assign pop       = (state == DRAIN) && win && drainable;

    assign wr_ptr_nxt = wr_ptr + PW'(push);
    assign rd_ptr_nxt = rd_ptr + PW'(pop);

    assign wr_entry_p0 = {address, writedata};

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT: begin
                if (win && drainable) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!win) begin
                    state_nxt = CLOSED;
                end else if (!drainable) begin
                    state_nxt = WAIT;
                end
            end
            CLOSED: begin
                if (vcount == '0) begin
                    state_nxt = WAIT;
                end
            end
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WAIT;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            level    <= wr_ptr_nxt - rd_ptr_nxt;
            overflow <= overflow || (host_wr && full);
            win_q    <= win;
        end
    end

    assign frame_done = win_q && !win;

    // ---- p0 -> p1: pop decision registers the RAM read ----
    memory #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_store (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry_p0),
        .re    (pop),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_raw_p1)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pop;
        end
    end

    // RAM output is not reset; gating on the strobe keeps the bus at zero.
    assign rd_entry_p1   = wsched_entry_t'(rd_raw_p1);
    assign tbl_write     = vld_p1;
    assign tbl_address   = vld_p1 ? rd_entry_p1.addr : '0;
    assign tbl_writedata = vld_p1 ? rd_entry_p1.data : '0;

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// Scoreboard bench for ppu_write_scheduler: queued host writes must reach the
// table port in order, only inside the vertical-blank window.
module tb_ppu_write_scheduler;
    import ppu_pkg::*;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset_n;
    logic        chipselect;
    logic        write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        tbl_write;
    logic [15:0] tbl_address;
    logic [31:0] tbl_writedata;
    logic [$clog2(DEPTH):0] level;
    logic        overflow;
    logic        frame_done;

    ppu_write_scheduler #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .chipselect    (chipselect),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .hcount        (hcount),
        .vcount        (vcount),
        .tbl_write     (tbl_write),
        .tbl_address   (tbl_address),
        .tbl_writedata (tbl_writedata),
        .level         (level),
        .overflow      (overflow),
        .frame_done    (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1);
    end

    wsched_entry_t sb[$];
    int  checks = 0;
    int  passed = 0;
    int  strobes = 0;
    int  fd_count = 0;
    bit  got_first = 0;
    int  first_v, first_h, last_v, last_h;
    bit  adv = 0;

    task automatic sample();
        wsched_entry_t e;
        @(negedge clk);
        if (reset_n && tbl_write === 1'b1) begin
            strobes++;
            last_v = int'(vcount);
            last_h = int'(hcount);
            if (!got_first) begin
                got_first = 1;
                first_v = last_v;
                first_h = last_h;
            end
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected got addr=%h data=%h required no strobe",
                         tbl_address, tbl_writedata);
            end else begin
                e = sb.pop_front();
                if ({tbl_address, tbl_writedata} !== {e.addr, e.data})
                    $display("FAIL sb_order got addr=%h data=%h required addr=%h data=%h",
                             tbl_address, tbl_writedata, e.addr, e.data);
                else
                    passed++;
            end
        end
        if (reset_n && frame_done === 1'b1) fd_count++;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (adv) begin
            if (hcount == 11'd1599) begin
                hcount = '0;
                vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount = hcount + 11'd1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic set_pos(input int v, input int h);
        vcount = 10'(v);
        hcount = 11'(h);
    endtask

    task automatic host_xfer(input logic [15:0] a, input logic [31:0] d, input bit queued);
        bit ok;
        wsched_entry_t e;
        ok = 0;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            sample();
            if (waitrequest === 1'b0) ok = 1;
            advance();
        end
        chipselect = 1'b0;
        write      = 1'b0;
        checks++;
        if (!ok) begin
            $display("FAIL host_accept addr=%h got waitrequest held required accept", a);
        end else begin
            passed++;
            if (queued) begin
                e.addr = a;
                e.data = d;
                sb.push_back(e);
            end
        end
    endtask

    task automatic host_commit();
`ifdef PPU_WSCHED_COMMIT_EN
        host_xfer(COMMIT_ADDR, 32'h0, 1'b0);
`else
        run(1);
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0; chipselect = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        set_pos(0, 0);
        adv = 0;
        repeat (3) advance();
        checks++; if (tbl_write !== 1'b0) $display("FAIL rst_tbl_write got=%b required=0", tbl_write); else passed++;
        checks++; if (level !== '0) $display("FAIL rst_level got=%0d required=0", level); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow got=%b required=0", overflow); else passed++;
        checks++; if (waitrequest !== 1'b0) $display("FAIL rst_waitrequest got=%b required=0", waitrequest); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got=%b required=0", frame_done); else passed++;
        checks++; if (tbl_address !== 16'h0) $display("FAIL rst_tbl_address got=%h required=0000", tbl_address); else passed++;
        reset_n = 1'b1;
        adv = 1;
    endtask

    task automatic test_hold_then_drain();
        int s0;
        set_pos(100, 0);
        host_xfer(16'h0001, 32'hA, 1'b1);
        host_xfer(16'h1002, 32'hB, 1'b1);
        host_xfer(16'h2003, 32'hC, 1'b1);
        host_commit();
        s0 = strobes;
        run(20);
        checks++; if (int'(level) != 3) $display("FAIL hold_level got=%0d required=3", level); else passed++;
        set_pos(479, 1590);
        run(10);
        checks++; if (strobes != s0) $display("FAIL hold_no_early_strobe got=%0d required=0", strobes - s0); else passed++;
        got_first = 0;
        run(8);
        checks++; if (strobes - s0 != 3) $display("FAIL drain_count got=%0d required=3", strobes - s0); else passed++;
        checks++; if (first_v != 480) $display("FAIL drain_first_line got=%0d required=480", first_v); else passed++;
        checks++; if (first_h != 2) $display("FAIL drain_first_cycle got=%0d required=2", first_h); else passed++;
        checks++; if (last_h != 4) $display("FAIL drain_last_cycle got=%0d required=4", last_h); else passed++;
        checks++; if (level !== '0) $display("FAIL drain_level got=%0d required=0", level); else passed++;
    endtask

    task automatic test_full();
        set_pos(100, 0);
        for (int i = 0; i < DEPTH - 1; i++)
            host_xfer(16'(i), 32'h1000_0000 + 32'(i), 1'b1);
        host_commit();
        host_xfer(16'(DEPTH - 1), 32'h1000_0000 + 32'(DEPTH - 1), 1'b1);
        checks++; if (waitrequest !== 1'b1) $display("FAIL full_waitrequest got=%b required=1", waitrequest); else passed++;
        checks++; if (int'(level) != DEPTH) $display("FAIL full_level got=%0d required=%0d", level, DEPTH); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL full_overflow_early got=%b required=0", overflow); else passed++;
        chipselect = 1'b1; write = 1'b1; address = 16'h0BAD; writedata = 32'hDEAD;
        sample();
        advance();
        chipselect = 1'b0; write = 1'b0;
        checks++; if (overflow !== 1'b1) $display("FAIL full_overflow got=%b required=1", overflow); else passed++;
        checks++; if (int'(level) != DEPTH) $display("FAIL full_level_after got=%0d required=%0d", level, DEPTH); else passed++;
        checks++; if (waitrequest !== 1'b1) $display("FAIL full_waitrequest_after got=%b required=1", waitrequest); else passed++;
    endtask

    task automatic test_window_close();
        int s0, fd0, s1;
        s0  = strobes;
        fd0 = fd_count;
        set_pos(523, 1579);
        run(23);
        checks++; if (strobes - s0 != 20) $display("FAIL close_strobes got=%0d required=20", strobes - s0); else passed++;
        checks++; if (last_v != 524) $display("FAIL close_last_line got=%0d required=524", last_v); else passed++;
        checks++; if (last_h != 0) $display("FAIL close_last_h got=%0d required=0", last_h); else passed++;
        checks++; if (fd_count - fd0 != 1) $display("FAIL close_frame_done got=%0d required=1", fd_count - fd0); else passed++;
        checks++; if (int'(level) != DEPTH - 20) $display("FAIL close_level got=%0d required=%0d", level, DEPTH - 20); else passed++;
        host_commit();
        s1 = strobes;
        set_pos(500, 0);
        run(10);
        checks++; if (strobes != s1) $display("FAIL closed_hold got=%0d required=0", strobes - s1); else passed++;
        set_pos(0, 0);
        run(3);
        set_pos(479, 1598);
        run(60);
        checks++; if (strobes - s0 != DEPTH) $display("FAIL next_frame_total got=%0d required=%0d", strobes - s0, DEPTH); else passed++;
        checks++; if (sb.size() != 0) $display("FAIL next_frame_left got=%0d required=0", sb.size()); else passed++;
        checks++; if (level !== '0) $display("FAIL next_frame_level got=%0d required=0", level); else passed++;
    endtask

    task automatic test_push_during_drain();
        int s0;
        s0 = strobes;
        set_pos(100, 0);
        for (int i = 0; i < 10; i++)
            host_xfer(16'h3000 + 16'(i), 32'hD0D0_0000 + 32'(i), 1'b1);
        host_commit();
        set_pos(479, 1599);
        run(4);
        for (int i = 0; i < 3; i++)
            host_xfer(16'h3100 + 16'(i), 32'hE0E0_0000 + 32'(i), 1'b1);
        host_commit();
        run(30);
        checks++; if (strobes - s0 != 13) $display("FAIL pdd_count got=%0d required=13", strobes - s0); else passed++;
        checks++; if (sb.size() != 0) $display("FAIL pdd_left got=%0d required=0", sb.size()); else passed++;
        checks++; if (level !== '0) $display("FAIL pdd_level got=%0d required=0", level); else passed++;
    endtask

`ifdef PPU_WSCHED_COMMIT_EN
    task automatic test_commit();
        int s0;
        s0 = strobes;
        set_pos(100, 0);
        host_xfer(16'h4001, 32'hAAAA, 1'b1);
        host_xfer(16'h4002, 32'hBBBB, 1'b1);
        host_commit();
        host_xfer(16'h4003, 32'hCCCC, 1'b1);
        set_pos(479, 1598);
        run(20);
        checks++; if (strobes - s0 != 2) $display("FAIL commit_first got=%0d required=2", strobes - s0); else passed++;
        checks++; if (int'(level) != 1) $display("FAIL commit_level got=%0d required=1", level); else passed++;
        set_pos(0, 0);
        run(2);
        set_pos(100, 0);
        host_commit();
        set_pos(479, 1598);
        run(20);
        checks++; if (strobes - s0 != 3) $display("FAIL commit_second got=%0d required=3", strobes - s0); else passed++;
        checks++; if (sb.size() != 0) $display("FAIL commit_left got=%0d required=0", sb.size()); else passed++;
    endtask
`else
    task automatic test_commit();
        int s0;
        s0 = strobes;
        set_pos(100, 0);
        host_xfer(COMMIT_ADDR, 32'h5555_0001, 1'b1);
        checks++; if (int'(level) != 1) $display("FAIL f000_level got=%0d required=1", level); else passed++;
        set_pos(479, 1598);
        run(20);
        checks++; if (strobes - s0 != 1) $display("FAIL f000_count got=%0d required=1", strobes - s0); else passed++;
        checks++; if (sb.size() != 0) $display("FAIL f000_left got=%0d required=0", sb.size()); else passed++;
    endtask
`endif

    task automatic test_reset_mid_drain();
        int s0;
        s0 = strobes;
        set_pos(100, 0);
        for (int i = 0; i < 8; i++)
            host_xfer(16'h5000 + 16'(i), 32'hF0F0_0000 + 32'(i), 1'b1);
        host_commit();
        set_pos(479, 1598);
        for (int i = 0; i < 30 && (strobes - s0) < 2; i++) run(1);
        checks++; if (strobes - s0 < 2) $display("FAIL rmd_drain_start got=%0d required>=2", strobes - s0); else passed++;
        checks++; if (overflow !== 1'b1) $display("FAIL rmd_overflow_sticky got=%b required=1", overflow); else passed++;
        #3;
        reset_n = 1'b0;
        #2;
        checks++; if (tbl_write !== 1'b0) $display("FAIL rmd_tbl_write got=%b required=0", tbl_write); else passed++;
        checks++; if (level !== '0) $display("FAIL rmd_level got=%0d required=0", level); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL rmd_overflow got=%b required=0", overflow); else passed++;
        sb.delete();
        advance();
        advance();
        reset_n = 1'b1;
        s0 = strobes;
        run(20);
        checks++; if (strobes != s0) $display("FAIL rmd_discarded got=%0d required=0", strobes - s0); else passed++;
        checks++; if (level !== '0) $display("FAIL rmd_level_after got=%0d required=0", level); else passed++;
    endtask

    initial begin
        test_reset();
        test_hold_then_drain();
        test_full();
        test_window_close();
        test_push_during_drain();
        test_commit();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ppu_write_scheduler.md
# ppu_write_scheduler

Queues host register writes destined for the PPU tables (attribute, color, pattern, sprite) and releases them only during vertical blanking, so the PPU's line-prep and output FSMs never read a table while it is being rewritten mid-frame. Sits between the Avalon-MM slave port and the PPU's table write port. Drives the PPU's `chipselect`/`write`/`address`/`writedata` inputs. Takes `hcount`/`vcount` from `vga_counters`.

## Interface
- `DEPTH`, 64: queue entries, power of two, 4..1024.
- `DRAIN_FIRST_LINE`, 480: first vcount of the drain window.
- `DRAIN_LAST_LINE`, 523: last vcount of the drain window. Line 524 is left free for line-0 prep.
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `chipselect`, `write`  in  1 each  host write strobe, Avalon-MM.
- `address`  in  16  host word address, PPU table map.
- `writedata`  in  32  host data.
- `waitrequest`  out  1  high when the queue is full; the host holds its write.
- `hcount`  in  11  from `vga_counters`.
- `vcount`  in  10  from `vga_counters`.
- `tbl_write`  out  1  one-cycle write strobe to the PPU.
- `tbl_address`  out  16  forwarded address.
- `tbl_writedata`  out  32  forwarded data.
- `level`  out  clog2(DEPTH)+1  occupied entries.
- `overflow`  out  1  sticky; set when a write is attempted while full. Cleared only by reset.
- `frame_done`  out  1  one-cycle pulse on the cycle the drain window closes.

## Operation
- **Push.** On `chipselect && write && !waitrequest`, store {address, writedata} at the tail.
- **waitrequest.** Combinational: `waitrequest = full`.
- **Window.** `win = (vcount >= DRAIN_FIRST_LINE) && (vcount <= DRAIN_LAST_LINE)`.
- **FSM, `WAIT`.** Go to `DRAIN` when `win` is true and there are drainable entries.
- **FSM, `DRAIN`.**
  - Pop one entry per cycle while `win` is true and entries remain.
  - Go to `WAIT` when the queue runs empty.
  - Go to `CLOSED` when `win` falls.
- **FSM, `CLOSED`.** Go to `WAIT` when `vcount == 0`. This guarantees one pass per frame.
- **frame_done.** Pulses on the first cycle `win` goes false after being true, in any state.
- **Simultaneous push and pop.** Allowed. `level` stays the same. A pushed entry is not poppable in its own cycle.
- **Wrap-around.** Pointers are clog2(DEPTH)+1 bits.
  - Full: pointer MSBs differ and the lower bits are equal.
  - Empty: pointers are equal.
- **Ordering.** Strict FIFO. No reordering between tables.
- **Reset.**
  - All outputs go to 0, except `waitrequest`, which is 0 because the queue is empty.
  - Pointers are cleared and the state returns to `WAIT`.
  - Queued writes are discarded. This includes an assertion mid-drain; `tbl_write` drops immediately.

## Timing
- **Pop to output.** A pop decided at edge k presents `tbl_write`/`tbl_address`/`tbl_writedata` from edge k+1 (registered read of the storage RAM).
- **Strobe.** `tbl_write` is high for exactly one cycle per entry. Back-to-back entries give a continuous strobe.
- **Window close.** The last pop occurs in a cycle where `win` is true. The final `tbl_write` can therefore appear one cycle after `win` falls; it always lands on line `DRAIN_LAST_LINE` + 1 with `hcount` < 2.
- **Level.** `level` is registered and updates the edge after a push or pop.
- **Throughput.** Minimum push-to-drain latency is 2 cycles when a push occurs inside the window.

## Configuration
- **`PPU_WSCHED_COMMIT_EN` defined.**
  - A host write to address 16'hF000 is a commit: it is not queued and sets `commit_ptr <= wr_ptr` (post-push pointer).
  - `DRAIN` pops only entries before `commit_ptr`. Uncommitted entries wait for a later commit and window.
  - A commit during `DRAIN` extends the boundary immediately.
- **Undefined.**
  - Every queued entry is drainable.
  - 16'hF000 is queued as an ordinary write (sprite region).

## Structure
- **Package `ppu_pkg`:**
  - `VACTIVE` = 480, `VTOTAL` = 525, `HTOTAL` = 1600.
  - `COMMIT_ADDR` = 16'hF000.
  - The `wsched_state_t` enum {WAIT, DRAIN, CLOSED}.
  - The 48-bit entry typedef {addr[15:0], data[31:0]}.
- **Sub-module.** Storage is one instance of the existing `memory` module: width 48, depth `DEPTH`, address width clog2(DEPTH). Pointer/FSM logic stays in `ppu_write_scheduler`.

## Test plan
- **Hold then drain.** Reset. Push 3 writes at vcount = 100: (0x0001, 0xA), (0x1002, 0xB), (0x2003, 0xC).
  - No `tbl_write` before vcount = 480.
  - At vcount 480, hcount 0, three consecutive strobes in order starting at cycle 2. `level` goes 3→0.
- **Full.** Push `DEPTH`+1 writes outside the window.
  - `waitrequest` is high after entry `DEPTH`.
  - An extra write attempted while full sets `overflow`.
  - `level` = `DEPTH`.
- **Window close.** Preload 64 entries. Start pushing at vcount = 523, hcount = 1580.
  - Exactly 20 or 21 strobes occur before the window closes, per the window-close rule.
  - `frame_done` pulses once.
  - The remainder drains in the next frame's window.
- **Push during drain.** Push while popping in the window. The pushed entry appears after all older entries, with no loss and no duplication.
- **Reset mid-drain.** Assert `reset_n` = 0 mid-drain. `tbl_write`, `level` and `overflow` all go to 0 asynchronously.
- **Commit (`PPU_WSCHED_COMMIT_EN`).**
  - Sequence: push A, B, commit, push C.
  - The window drains only A and B.
  - After a commit in the next frame, C drains.
